// File: rtl/scan_doubler.sv
// Line-doubling scan converter: captures each input line into a ping-pong buffer and replays it twice at double dot rate.
// Optional build macro SCAN_DOUBLER_SCANLINES_EN blanks the second (repeat) pass for a CRT scanline look.
module scan_doubler #(
  parameter int MAX_PIXELS       = 1024,
  parameter int OUT_HSYNC_PIXELS = 96,
  parameter int OUT_BACK_PORCH   = 48
) (
  input  logic sys_clock_i,
  input  logic sys_reset_i,
  input  logic pix_en_i,
  input  logic out_pix_en_i,
  input  logic video_i,
  input  logic h_sync_i,
  input  logic v_sync_i,
  output logic vga_video_o,
  output logic vga_h_sync_o,
  output logic vga_v_sync_o,
  output logic overflow_o
);

  localparam int AW = $clog2(MAX_PIXELS);
  localparam int CW = $clog2(MAX_PIXELS + OUT_HSYNC_PIXELS + OUT_BACK_PORCH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_SYNC   = 2'd2;
  localparam logic [1:0] S_PORCH  = 2'd3;

  localparam logic [CW-1:0] HS_LAST = CW'(OUT_HSYNC_PIXELS - 1);
  localparam logic [CW-1:0] BP_LAST = CW'(OUT_BACK_PORCH - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW:0]   ADR_ONE = (AW + 1)'(1);

  // Capture side
  logic          r_hs_prev;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [AW:0]   r_wr_addr;
  logic [AW:0]   r_line_len;
  logic          r_overflow;
  logic          w_line_start;
  logic          w_capture;
  logic          w_wr_en;

  // Replay side
  logic [1:0]    r_state;
  logic          r_repeat;
  logic [CW-1:0] r_cnt;
  logic          r_vs;
  logic [CW-1:0] w_len;
  logic [CW-1:0] w_cnt_inc;
  logic          w_pix_on;

  // Line buffer and output pipeline
  logic          r_mem [2*MAX_PIXELS];
  logic          r_rd_data;
  logic          r_p1_valid;
  logic          r_p1_pix_on;
  logic          r_p1_h;
  logic          r_p1_v;
  logic          r_vga_video;
  logic          r_vga_h;
  logic          r_vga_v;

  assign w_line_start = h_sync_i & ~r_hs_prev;
  assign w_capture    = pix_en_i & ~h_sync_i;
  // A pixel arriving with the address already at MAX_PIXELS is dropped, not wrapped.
  assign w_wr_en      = w_capture & ~r_wr_addr[AW];
  assign w_len        = CW'(r_line_len);
  assign w_cnt_inc    = r_cnt + CNT_ONE;

`ifdef SCAN_DOUBLER_SCANLINES_EN
  assign w_pix_on = (r_state == S_ACTIVE) && (r_cnt != w_len) && !r_repeat;
`else
  assign w_pix_on = (r_state == S_ACTIVE) && (r_cnt != w_len);
`endif

  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      r_hs_prev  <= 1'b0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_wr_addr  <= '0;
      r_line_len <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_hs_prev <= h_sync_i;
      if (w_line_start) begin
        r_line_len <= r_wr_addr;
        r_wr_bank  <= ~r_wr_bank;
        r_rd_bank  <= r_wr_bank;
        r_wr_addr  <= '0;
      end else if (w_capture) begin
        if (r_wr_addr[AW]) begin
          r_overflow <= 1'b1;
        end else begin
          r_wr_addr <= r_wr_addr + ADR_ONE;
        end
      end
    end
  end

  // Simple dual-port RAM: write from the capture bank, synchronous read from the replay bank.
  always_ff @(posedge sys_clock_i) begin
    if (w_wr_en) begin
      r_mem[{r_wr_bank, r_wr_addr[AW-1:0]}] <= video_i;
    end
    r_rd_data <= r_mem[{r_rd_bank, r_cnt[AW-1:0]}];
  end

  // A line start always wins, so a new line aborts any replay in progress.
  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      r_state  <= S_IDLE;
      r_repeat <= 1'b0;
      r_cnt    <= '0;
      r_vs     <= 1'b0;
    end else if (w_line_start) begin
      r_state  <= S_ACTIVE;
      r_repeat <= 1'b0;
      r_cnt    <= '0;
      r_vs     <= v_sync_i;
    end else if (out_pix_en_i) begin
      case (r_state)
        S_ACTIVE: begin
          if (r_cnt == w_len || w_cnt_inc == w_len) begin
            r_state <= S_SYNC;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_SYNC: begin
          if (r_cnt == HS_LAST) begin
            r_state <= S_PORCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_PORCH: begin
          if (r_cnt == BP_LAST) begin
            r_cnt <= '0;
            if (!r_repeat) begin
              r_state  <= S_ACTIVE;
              r_repeat <= 1'b1;
              r_vs     <= v_sync_i;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Stage 1 lines up with the RAM read; stage 2 drives the pins, two clocks after the strobe.
  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      r_p1_valid  <= 1'b0;
      r_p1_pix_on <= 1'b0;
      r_p1_h      <= 1'b0;
      r_p1_v      <= 1'b0;
      r_vga_video <= 1'b0;
      r_vga_h     <= 1'b0;
      r_vga_v     <= 1'b0;
    end else begin
      r_p1_valid <= out_pix_en_i;
      if (out_pix_en_i) begin
        r_p1_pix_on <= w_pix_on;
        r_p1_h      <= (r_state == S_SYNC);
        r_p1_v      <= r_vs;
      end
      if (r_p1_valid) begin
        r_vga_video <= r_rd_data & r_p1_pix_on;
        r_vga_h     <= r_p1_h;
        r_vga_v     <= r_p1_v;
      end
    end
  end

  assign vga_video_o  = r_vga_video;
  assign vga_h_sync_o = r_vga_h;
  assign vga_v_sync_o = r_vga_v;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_scan_doubler.sv
// Bench for scan_doubler: random lines are captured and replayed; each output strobe is compared against a
// per-line expected sample stream ({v_sync, h_sync, video}) built from the line contents.
module tb_scan_doubler;

  localparam int MAXP = 8;
  localparam int HSP  = 96;
  localparam int BPP  = 48;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic pix_en = 1'b0;
  logic out_en = 1'b0;
  logic video  = 1'b0;
  logic hs     = 1'b0;
  logic vs     = 1'b0;
  logic vga_video;
  logic vga_hs;
  logic vga_vs;
  logic ovf;
  logic [2:0] w_out;

  scan_doubler #(
    .MAX_PIXELS      (MAXP),
    .OUT_HSYNC_PIXELS(HSP),
    .OUT_BACK_PORCH  (BPP)
  ) dut (
    .sys_clock_i (clk),
    .sys_reset_i (rst),
    .pix_en_i    (pix_en),
    .out_pix_en_i(out_en),
    .video_i     (video),
    .h_sync_i    (hs),
    .v_sync_i    (vs),
    .vga_video_o (vga_video),
    .vga_h_sync_o(vga_hs),
    .vga_v_sync_o(vga_vs),
    .overflow_o  (ovf)
  );

  assign w_out = {vga_vs, vga_hs, vga_video};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [2:0] exp_q[$];
  logic       cap_q[$];
  logic       cur_v    = 1'b0;
  logic [2:0] last_out = 3'b000;
  logic       exp_ovf  = 1'b0;

  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int full_len(input int n);
    int k;
    k = (n > MAXP) ? MAXP : n;
    return 2 * (k + HSP + BPP);
  endfunction

  // A line start replaces whatever is still pending with two passes of the captured line.
  task automatic load_line(input logic v);
    logic px;
    exp_q.delete();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < cap_q.size(); i++) begin
        px = cap_q[i];
`ifdef SCAN_DOUBLER_SCANLINES_EN
        if (pass == 1) px = 1'b0;
`endif
        exp_q.push_back({v, 1'b0, px});
      end
      repeat (HSP) exp_q.push_back({v, 2'b10});
      repeat (BPP) exp_q.push_back({v, 2'b00});
    end
    cur_v = v;
    cap_q.delete();
  endtask

  task automatic capture(input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pix_en = 1'b1;
      video  = pat[n-1-i];
      if (cap_q.size() < MAXP) cap_q.push_back(pat[n-1-i]);
      if (i >= MAXP) exp_ovf = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
      video  = 1'($urandom_range(0, 1));
    end
    check_eq("overflow", {2'b00, ovf}, {2'b00, exp_ovf});
  endtask

  task automatic line_start(input logic v, input logic conflict);
    @(negedge clk);
    vs     = v;
    hs     = 1'b1;
    pix_en = conflict;
    video  = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    load_line(v);
    @(negedge clk);
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    hs     = 1'b0;
  endtask

  task automatic strobe();
    logic [2:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = {cur_v, 2'b00};
    @(negedge clk);
    out_en = 1'b1;
    @(negedge clk);
    out_en = 1'b0;
    check_eq("hold", w_out, last_out);
    @(negedge clk);
    check_eq("sample", w_out, e);
    last_out = e;
  endtask

  task automatic play(input int k);
    for (int i = 0; i < k; i++) strobe();
  endtask

  task automatic model_reset();
    exp_q.delete();
    cap_q.delete();
    cur_v    = 1'b0;
    last_out = 3'b000;
    exp_ovf  = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_out", w_out, 3'b000);
    check_eq("rst_ovf", {2'b00, ovf}, 3'b000);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_out", w_out, 3'b000);
    end
    check_eq("idle_ovf", {2'b00, ovf}, 3'b000);
    play(4);

    // Reference pattern, then an all-ones line with v_sync high and a pixel strobe on the edge cycle
    capture(8, 16'b10110001);
    line_start(1'b0, 1'b0);
    play(full_len(8) + 3);
    capture(8, 16'h00FF);
    line_start(1'b1, 1'b1);
    play(full_len(8) + 2);

    // New line arrives during the first porch: replay restarts with the new line
    capture(6, 16'($urandom));
    line_start(1'b1, 1'b0);
    play(6 + HSP + 10);
    capture(5, 16'($urandom));
    line_start(1'b1, 1'b0);
    play(full_len(5) + 2);
    capture(4, 16'($urandom));
    line_start(1'b0, 1'b0);
    play(full_len(4) + 2);

    // Random lines, with capture interleaved into the tail of the previous replay
    for (int it = 0; it < 16; it++) begin
      int n;
      n = $urandom_range(1, MAXP);
      capture(n, 16'($urandom));
      play($urandom_range(0, 40));
      line_start(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      play($urandom_range(n, full_len(n) + 4));
    end

    // Over-long line: truncated to MAXP pixels and overflow stays set until reset
    capture(12, 16'($urandom));
    line_start(1'b0, 1'b0);
    play(full_len(12) + 2);
    capture(3, 16'($urandom));
    line_start(1'b1, 1'b0);
    play(20);

    // Reset in the middle of a line
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_eq("midrst_out", w_out, 3'b000);
    check_eq("midrst_ovf", {2'b00, ovf}, 3'b000);
    rst = 1'b0;
    model_reset();
    play(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_doubler.md
Name: scan_doubler

Overview:
- Consumes the dot-generator output (video, h_sync, v_sync) and regenerates each scanline twice at double pixel rate, for VGA-rate displays.
- Ping-pong line buffer: one bank captures the current input line while the other bank is replayed twice.
- Sits directly downstream of the video block; its outputs drive the external video DAC/connector.

Parameters:
- MAX_PIXELS, 1024: pixel depth of each line-buffer bank. Power of two, at least 8.
- OUT_HSYNC_PIXELS, 96: output h_sync pulse width, in out_pix_en_i pulses.
- OUT_BACK_PORCH, 48: blank interval after the output h_sync, in out_pix_en_i pulses.

Ports:
- sys_clock_i, in, 1: system clock. The only clock.
- sys_reset_i, in, 1: synchronous, active-high reset.
- pix_en_i, in, 1: input dot strobe (clk16_en in 80-col mode, clk8_en in 40-col mode).
- out_pix_en_i, in, 1: output dot strobe at twice the pix_en_i rate.
- video_i, in, 1: input pixel from the dot generator.
- h_sync_i, in, 1: input horizontal sync, active high.
- v_sync_i, in, 1: input vertical sync, active high.
- vga_video_o, out, 1: doubled-rate pixel.
- vga_h_sync_o, out, 1: output horizontal sync, active high.
- vga_v_sync_o, out, 1: output vertical sync, active high, aligned to output line starts.
- overflow_o, out, 1: sticky flag; a line exceeded MAX_PIXELS.

Behaviour:
- Reset values:
  - all outputs 0;
  - FSM in IDLE, repeat = 0;
  - write bank = 0, wr_addr = 0, line_len = 0;
  - h_sync edge detector primed with 0.
- Reset asserted mid-line: the FSM enters IDLE on the next clock. Buffer contents are don't-care.
- Capture:
  - On each pix_en_i with h_sync_i = 0, write video_i to [wr_bank][wr_addr], then increment wr_addr.
  - When wr_addr reaches MAX_PIXELS, further pixels are dropped (no wrap) and overflow_o is set.
  - While h_sync_i = 1, no pixels are captured.
- Line end: a rising edge of h_sync_i (previous 0, current 1, sampled each sys_clock_i) does all of the following in one cycle:
  - line_len <= wr_addr;
  - wr_bank toggles; the read bank is set to the old wr_bank;
  - wr_addr <= 0;
  - line_start is pulsed.
- Pixel-strobe conflict: if pix_en_i coincides with the rising-edge cycle, that pixel is not captured, because h_sync_i = 1.
- Output FSM (states IDLE, ACTIVE, SYNC, PORCH). An internal counter cnt advances only on out_pix_en_i.
  - IDLE: video 0, h_sync 0. On line_start: enter ACTIVE with repeat = 0, cnt = 0.
  - ACTIVE: each out_pix_en_i reads pixel cnt of the read bank, then cnt++. When cnt = line_len: enter SYNC, cnt = 0. If line_len = 0, ACTIVE lasts 0 pixels and SYNC follows on the next out_pix_en_i.
  - SYNC: h_sync asserted. After OUT_HSYNC_PIXELS strobes: enter PORCH, cnt = 0.
  - PORCH: video 0. After OUT_BACK_PORCH strobes:
    - if repeat = 0: enter ACTIVE with repeat = 1;
    - otherwise: enter IDLE.
  - A line_start while not in IDLE aborts the current line and restarts ACTIVE with repeat = 0 (resync). The new read bank is used.
- vga_v_sync_o loads v_sync_i on every ACTIVE entry and holds between entries.
- Pipeline timing:
  - The line buffer has a 1-cycle synchronous read.
  - vga_video_o, vga_h_sync_o and vga_v_sync_o are registered, and all update exactly 2 sys_clock_i cycles after the out_pix_en_i that produced them.
  - The three outputs stay mutually aligned; each value holds until the next update.
- Buffer storage: 2 × MAX_PIXELS bits, inferred as a simple dual-port RAM with independent write and read addresses.

Optional Feature:
- Macro: SCAN_DOUBLER_SCANLINES_EN.
- When defined: during the repeat = 1 pass, vga_video_o is forced to 0. Sync timing is unchanged. This gives a CRT scanline look.
- When undefined: both passes output identical pixel data.

Test Plan:
- Reset, then 10 idle cycles -> all outputs 0 and overflow_o = 0; vga_h_sync_o never rises.
- Capture line 1,0,1,1,0,0,0,1 (8 pixels), then raise h_sync_i:
  - two ACTIVE passes each show 10110001 over 8 out strobes, 2 clocks after each strobe;
  - each pass is followed by 96 strobes of h_sync and 48 strobes of blank.
- MAX_PIXELS = 8, feed 12 pixels, then h_sync_i -> line_len = 8, first 8 pixels replayed, overflow_o = 1 and held until sys_reset_i.
- Second h_sync_i rising edge during the first PORCH -> FSM restarts ACTIVE with repeat = 0, showing the newly captured line; no third repeat of the old line.
- v_sync_i = 1 around line start N -> vga_v_sync_o = 1 from the first ACTIVE entry after that line start and held across the following ACTIVE entries while v_sync_i = 1; returns to 0 at the first ACTIVE entry after v_sync_i = 0.
- With SCAN_DOUBLER_SCANLINES_EN and line 11111111 -> pass 0 outputs eight 1s, pass 1 outputs eight 0s; sync timing identical to the undefined build.
